div_seq: RTL

- Upstream sequencer for the 4-bit serial signed divider.
- Accepts one operand pair {dividend, divisor} per transaction on a valid/ready port and serialises it into the divider's two-beat `valid_in`/`d_in` protocol.
- Waits for the divider's one-cycle `valid_out` pulse, then captures `d_out`/`error_out`.
- Presents the result on a valid/ready result port, with a watchdog on missing responses.

---
 rtl/div_seq.sv | 120 ++++++++++++
 1 files changed

// File: rtl/div_seq.sv
// Sequencer in front of the two-beat serial signed divider: serialises an
// operand pair, waits for the quotient pulse and holds it for the consumer.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | ready for an operand pair; op_ready high
// SEND_A | dividend on div_d_in, div_valid_in high (first beat)
// SEND_B | divisor on div_d_in, div_valid_in high (second beat)
// WAIT   | waiting for div_valid_out; watchdog counting down
// HOLD   | result (or watchdog fault) presented until res_ready
module div_seq #(
   parameter int W       = 4,
   parameter int TIMEOUT = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         op_valid,
   output logic         op_ready,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   output logic         div_valid_in,
   output logic [W-1:0] div_d_in,
   input  logic [W-1:0] div_d_out,
   input  logic         div_valid_out,
   input  logic         div_error_out,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [W-1:0] res_data,
   output logic         res_error,
   output logic         res_timeout,
   output logic         busy
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SEND_A = 3'd1;
   localparam logic [2:0] S_SEND_B = 3'd2;
   localparam logic [2:0] S_WAIT   = 3'd3;
   localparam logic [2:0] S_HOLD   = 3'd4;

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] WDOG_LOAD = CW'(TIMEOUT - 1);

   logic [2:0]    state;
   logic [CW-1:0] wdog_cnt;
   logic [W-1:0]  b_reg;

   // Gated by reset so no pair is taken while the block is held in reset.
   assign op_ready = reset && (state == S_IDLE);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= S_IDLE;
         div_valid_in <= 1'b0;
         div_d_in     <= '0;
         res_valid    <= 1'b0;
         res_data     <= '0;
         res_error    <= 1'b0;
         res_timeout  <= 1'b0;
         busy         <= 1'b0;
         wdog_cnt     <= '0;
         b_reg        <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (op_valid) begin
                  b_reg        <= op_b;
                  div_valid_in <= 1'b1;
                  div_d_in     <= op_a;
                  busy         <= 1'b1;
                  state        <= S_SEND_A;
               end
            end
            S_SEND_A: begin
               div_valid_in <= 1'b1;
               div_d_in     <= b_reg;
               state        <= S_SEND_B;
            end
            S_SEND_B: begin
               div_valid_in <= 1'b0;
               div_d_in     <= '0;
               wdog_cnt     <= WDOG_LOAD;
               state        <= S_WAIT;
            end
            S_WAIT: begin
               // A real response wins over a watchdog expiry on the same edge.
               if (div_valid_out) begin
                  res_data    <= div_d_out;
                  res_error   <= div_error_out;
                  res_timeout <= 1'b0;
                  res_valid   <= 1'b1;
                  state       <= S_HOLD;
               end else if (wdog_cnt == '0) begin
                  res_data    <= '0;
                  res_error   <= 1'b0;
                  res_timeout <= 1'b1;
                  res_valid   <= 1'b1;
                  state       <= S_HOLD;
               end else begin
                  wdog_cnt <= wdog_cnt - 1'b1;
               end
            end
            S_HOLD: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: begin
               div_valid_in <= 1'b0;
               div_d_in     <= '0;
               res_valid    <= 1'b0;
               busy         <= 1'b0;
               state        <= S_IDLE;
            end
         endcase
      end
   end

endmodule
